// File: rtl/run_monitor_pkg.sv
// run_monitor_pkg: FSM state encoding and default parameter values shared by run_monitor and halt_detector.
package run_monitor_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_PC_W        = 16;
  localparam int DEF_ADDR_W      = 4;
  localparam int DEF_N_WATCH     = 2;
  localparam int DEF_CNT_W       = 32;
  localparam int DEF_MAX_CYCLES  = 1000;
  localparam int DEF_HALT_REPEAT = 2;
endpackage

// File: rtl/run_monitor_halt_detector.sv
// halt_detector: flags a halt when pc has matched the previous enabled cycle's pc HALT_REPEAT times in a row.
module halt_detector
  import run_monitor_pkg::*;
#(
  parameter int PC_W        = DEF_PC_W,
  parameter int HALT_REPEAT = DEF_HALT_REPEAT
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [PC_W-1:0] pc,
  input  logic            enable,
  input  logic            clear,
  output logic            halt
);
  localparam int RW = $clog2(HALT_REPEAT + 1);
  logic [PC_W-1:0] r_prev;
  logic            r_valid;
  logic [RW-1:0]   r_rep;
  logic            w_same;
  logic [RW-1:0]   w_rep_nxt;
  // r_valid keeps the first enabled cycle from comparing against a stale pc
  assign w_same    = r_valid && (pc == r_prev);
  assign w_rep_nxt = w_same ? r_rep + RW'(1) : '0;
  assign halt      = enable && w_same && (int'(w_rep_nxt) >= HALT_REPEAT);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_prev  <= '0;
      r_valid <= 1'b0;
      r_rep   <= '0;
    end else if (clear) begin
      r_valid <= 1'b0;
      r_rep   <= '0;
    end else if (enable) begin
      r_prev  <= pc;
      r_valid <= 1'b1;
      r_rep   <= w_rep_nxt;
    end
  end
endmodule

// File: rtl/run_monitor.sv
// run_monitor: times a CPU run, shadows watched registers and ends on halt or timeout.
// Define RUN_MONITOR_JR_COUNT_EN to add the saturating jr_count jump-register counter.
module run_monitor
  import run_monitor_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int PC_W        = DEF_PC_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int N_WATCH     = DEF_N_WATCH,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int MAX_CYCLES  = DEF_MAX_CYCLES,
  parameter int HALT_REPEAT = DEF_HALT_REPEAT
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [PC_W-1:0]           pc,
  input  logic                      jump_reg_sl,
  input  logic                      reg_write_en,
  input  logic [ADDR_W-1:0]         reg_dest_addr,
  input  logic [DATA_W-1:0]         reg_wr_data,
  input  logic [N_WATCH*ADDR_W-1:0] watch_addr,
  input  logic                      result_ack,
  output logic                      busy,
  output logic                      done,
  output logic                      timeout,
  output logic [CNT_W-1:0]          cycle_count,
  output logic [N_WATCH*DATA_W-1:0] watch_data
`ifdef RUN_MONITOR_JR_COUNT_EN
  ,
  output logic [CNT_W-1:0]          jr_count
`endif
);
  state_t                    r_state;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_timeout;
  logic [CNT_W-1:0]          r_cnt;
  logic [N_WATCH*DATA_W-1:0] r_watch;
  logic                      w_halt;
  logic                      w_launch;
  logic [CNT_W-1:0]          w_cnt_nxt;
  logic                      w_to;
`ifdef RUN_MONITOR_JR_COUNT_EN
  logic [CNT_W-1:0]          r_jr;
  assign jr_count = r_jr;
`else
  logic                      w_unused;
  assign w_unused = jump_reg_sl;
`endif
  assign busy        = r_busy;
  assign done        = r_done;
  assign timeout     = r_timeout;
  assign cycle_count = r_cnt;
  assign watch_data  = r_watch;
  assign w_launch    = (r_state == S_IDLE) && start;
  assign w_cnt_nxt   = r_cnt + CNT_W'(1);
  assign w_to        = w_cnt_nxt == CNT_W'(MAX_CYCLES);
  halt_detector #(.PC_W(PC_W), .HALT_REPEAT(HALT_REPEAT)) u_halt (
    .clock (clock),
    .reset (reset),
    .pc    (pc),
    .enable(r_state == S_RUN),
    .clear (w_launch),
    .halt  (w_halt)
  );
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
      r_watch   <= '0;
`ifdef RUN_MONITOR_JR_COUNT_EN
      r_jr      <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_state   <= S_RUN;
          r_busy    <= 1'b1;
          r_timeout <= 1'b0;
          r_cnt     <= '0;
          r_watch   <= '0;
`ifdef RUN_MONITOR_JR_COUNT_EN
          r_jr      <= '0;
`endif
        end
        S_RUN: begin
          r_cnt <= w_cnt_nxt;
          for (int i = 0; i < N_WATCH; i++)
            if (reg_write_en && reg_dest_addr == watch_addr[i*ADDR_W +: ADDR_W])
              r_watch[i*DATA_W +: DATA_W] <= reg_wr_data;
`ifdef RUN_MONITOR_JR_COUNT_EN
          if (jump_reg_sl && !(&r_jr)) r_jr <= r_jr + CNT_W'(1);
`endif
          // a halt on the timeout edge is reported as a clean halt
          if (w_halt || w_to) begin
            r_state   <= S_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_timeout <= !w_halt;
          end
        end
        S_DONE: if (result_ack) begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_run_monitor.sv
// tb_run_monitor: directed table, hand sequences and randomized runs against a behavioural model of run_monitor.
module tb_run_monitor;
  localparam int DW = 16, PW = 16, AW = 4, NW = 2, CW = 32, MAXC = 20, HR = 2;
  logic clock = 1'b0;
  logic reset, start, jump_reg_sl, reg_write_en, result_ack;
  logic [PW-1:0] pc;
  logic [AW-1:0] reg_dest_addr;
  logic [DW-1:0] reg_wr_data;
  logic [NW*AW-1:0] watch_addr;
  logic busy, done, timeout;
  logic [CW-1:0] cycle_count;
  logic [NW*DW-1:0] watch_data;
`ifdef RUN_MONITOR_JR_COUNT_EN
  logic [CW-1:0] jr_count;
`endif
  run_monitor #(.DATA_W(DW), .PC_W(PW), .ADDR_W(AW), .N_WATCH(NW), .CNT_W(CW),
                .MAX_CYCLES(MAXC), .HALT_REPEAT(HR)) dut (
    .clock(clock), .reset(reset), .start(start), .pc(pc), .jump_reg_sl(jump_reg_sl),
    .reg_write_en(reg_write_en), .reg_dest_addr(reg_dest_addr), .reg_wr_data(reg_wr_data),
    .watch_addr(watch_addr), .result_ack(result_ack), .busy(busy), .done(done),
    .timeout(timeout), .cycle_count(cycle_count), .watch_data(watch_data)
`ifdef RUN_MONITOR_JR_COUNT_EN
    , .jr_count(jr_count)
`endif
  );
  always #5 clock = ~clock;
  int tests = 0, fails = 0;
  logic [PW-1:0] pc_a[0:40];
  bit            we_a[0:40];
  logic [AW-1:0] ad_a[0:40];
  logic [DW-1:0] dt_a[0:40];
  bit            jr_a[0:40];
  typedef struct {int stall; int exp_cyc; bit exp_to;} vec_t;
  vec_t tbl[5];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // pc advances by 2 each cycle until cycle s, then stays put (s=0: never stalls)
  task automatic fill_stall(input int s);
    for (int c = 0; c <= 40; c++) begin
      pc_a[c] = PW'(2 * (((s != 0) && (c > s)) ? s - 1 : c - 1));
      we_a[c] = 0; ad_a[c] = '0; dt_a[c] = '0; jr_a[c] = 0;
    end
  endtask
  task automatic launch();
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
  endtask
  task automatic run(output int got);
    got = 0;
    for (int c = 1; c <= 40 && got == 0; c++) begin
      pc = pc_a[c]; reg_write_en = we_a[c]; reg_dest_addr = ad_a[c];
      reg_wr_data = dt_a[c]; jump_reg_sl = jr_a[c];
      @(posedge clock); #1;
      if (done) got = c;
    end
    reg_write_en = 1'b0; jump_reg_sl = 1'b0;
    if (got == 0) chk("run_bound", 0, 1);
  endtask
  task automatic ack();
    result_ack = 1'b1;
    @(posedge clock); #1 result_ack = 1'b0;
  endtask
  // end cycle = first c whose pc equals each of the HR previous pcs, else MAXC
  task automatic model(input logic [NW*AW-1:0] wa, output int cyc, output bit to,
                       output logic [NW*DW-1:0] wd);
    cyc = MAXC; to = 1;
    for (int c = HR + 1; c <= MAXC; c++) begin
      bit all = 1;
      for (int k = c - HR; k < c; k++) if (pc_a[k] != pc_a[c]) all = 0;
      if (all) begin cyc = c; to = 0; break; end
    end
    wd = '0;
    for (int ch = 0; ch < NW; ch++)
      for (int c = 1; c <= cyc; c++)
        if (we_a[c] && ad_a[c] == wa[ch*AW +: AW]) wd[ch*DW +: DW] = dt_a[c];
  endtask
  initial begin
    int got, mc; bit mto; logic [NW*DW-1:0] mwd;
    tbl[0] = '{4, 6, 0};
    tbl[1] = '{0, 20, 1};
    tbl[2] = '{18, 20, 0};
    tbl[3] = '{19, 20, 1};
    tbl[4] = '{1, 3, 0};
    reset = 1; start = 0; jump_reg_sl = 0; reg_write_en = 0; result_ack = 0;
    pc = '0; reg_dest_addr = '0; reg_wr_data = '0; watch_addr = {4'd15, 4'd3};
    #2;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_to", timeout, 0);
    chk("rst_cnt", cycle_count, 0); chk("rst_watch", watch_data, 0);
    #10 reset = 0;
    for (int i = 0; i < 5; i++) begin
      fill_stall(tbl[i].stall);
      launch();
      chk("tbl_busy", busy, 1);
      chk("tbl_cnt0", cycle_count, 0);
      run(got);
      chk("tbl_got", got, tbl[i].exp_cyc);
      chk("tbl_cnt", cycle_count, tbl[i].exp_cyc);
      chk("tbl_to", timeout, tbl[i].exp_to);
      chk("tbl_busy_done", busy, 0);
      ack();
      chk("tbl_ack_done", done, 0);
    end
    // watched-register capture, including a write to an unwatched register
    fill_stall(6);
    we_a[1] = 1; ad_a[1] = 4'd3;  dt_a[1] = 16'd7;
    we_a[2] = 1; ad_a[2] = 4'd15; dt_a[2] = 16'd12;
    we_a[3] = 1; ad_a[3] = 4'd3;  dt_a[3] = 16'd9;
    we_a[4] = 1; ad_a[4] = 4'd5;  dt_a[4] = 16'd99;
    launch(); run(got);
    chk("watch_data", watch_data, {16'd12, 16'd9});
    chk("watch_cnt", cycle_count, 8);
    ack();
    // capture must not happen outside RUN
    reg_write_en = 1; reg_dest_addr = 4'd3; reg_wr_data = 16'hdead;
    @(posedge clock); #1 reg_write_en = 0;
    chk("idle_nocap", watch_data, {16'd12, 16'd9});
    // reset in the middle of a run
    fill_stall(0);
    we_a[1] = 1; ad_a[1] = 4'd3; dt_a[1] = 16'h55;
    launch();
    for (int c = 1; c <= 4; c++) begin
      pc = pc_a[c]; reg_write_en = we_a[c]; reg_dest_addr = ad_a[c]; reg_wr_data = dt_a[c];
      @(posedge clock); #1;
    end
    reg_write_en = 0;
    chk("pre_rst_cnt", cycle_count, 4);
    chk("pre_rst_watch", watch_data, {16'd0, 16'h55});
    #3 reset = 1;
    #1;
    chk("mid_rst_busy", busy, 0); chk("mid_rst_done", done, 0); chk("mid_rst_to", timeout, 0);
    chk("mid_rst_cnt", cycle_count, 0); chk("mid_rst_watch", watch_data, 0);
    #2 reset = 0;
    @(posedge clock); #1;
    chk("post_rst_idle", busy, 0);
    chk("post_rst_nodone", done, 0);
    fill_stall(4);
    launch(); run(got);
    chk("rerun_cnt", cycle_count, 6);
    chk("rerun_to", timeout, 0);
    ack();
    // halt on the timeout edge, then start ignored in DONE, then start+ack
    fill_stall(18);
    launch(); run(got);
    chk("tie_to", timeout, 0);
    start = 1;
    @(posedge clock); #1 start = 0;
    chk("done_start_done", done, 1);
    chk("done_start_busy", busy, 0);
    chk("done_start_cnt", cycle_count, 20);
    start = 1; result_ack = 1;
    @(posedge clock); #1 start = 0; result_ack = 0;
    chk("start_ack_done", done, 0);
    chk("start_ack_busy", busy, 0);
    @(posedge clock); #1;
    chk("start_ack_idle", busy, 0);
    result_ack = 1;
    @(posedge clock); #1 result_ack = 0;
    chk("idle_ack_done", done, 0);
    chk("idle_ack_cnt", cycle_count, 20);
`ifdef RUN_MONITOR_JR_COUNT_EN
    jump_reg_sl = 1;
    @(posedge clock); #1 jump_reg_sl = 0;
    fill_stall(8);
    jr_a[2] = 1; jr_a[4] = 1; jr_a[5] = 1;
    launch(); run(got);
    chk("jr_count", jr_count, 3);
    ack();
`endif
    // randomized runs against the model
    for (int r = 0; r < 30; r++) begin
      logic [NW*AW-1:0] wa;
      wa = NW*AW'($urandom);
      if ($urandom_range(0, 3) == 0) wa[AW +: AW] = wa[0 +: AW];
      watch_addr = wa;
      pc_a[1] = PW'($urandom);
      for (int c = 2; c <= 40; c++)
        pc_a[c] = ($urandom_range(0, 2) == 0) ? pc_a[c-1] : PW'($urandom_range(0, 7));
      for (int c = 1; c <= 40; c++) begin
        we_a[c] = ($urandom_range(0, 1) == 1);
        ad_a[c] = ($urandom_range(0, 1) == 1) ? wa[$urandom_range(0, NW-1)*AW +: AW] : AW'($urandom);
        dt_a[c] = DW'($urandom);
        jr_a[c] = 0;
      end
      model(wa, mc, mto, mwd);
      launch(); run(got);
      chk("rnd_got", got, mc);
      chk("rnd_cnt", cycle_count, mc);
      chk("rnd_to", timeout, mto);
      chk("rnd_watch", watch_data, mwd);
      ack();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
